mem_test_engine: RTL



---
 rtl/mem_test_engine_pkg.sv | 27 ++
 rtl/mem_test_engine_pattern_gen.sv | 46 ++++
 rtl/mem_test_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_test_engine_pkg.sv
// Shared types and constants for the memory self-test engine.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package mem_test_engine_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_ADDR  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_LFSR  = 2'd3
  } mem_test_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } mem_test_state_t;

  // Galois right-shift form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/mem_test_engine_pattern_gen.sv
// Test pattern generator: current word pattern from mode, index, address and LFSR state.
// Latency: pattern is combinational from registered inputs; LFSR advances on the step edge.
// Backpressure: none; the caller only pulses step when a word completes.
module mem_test_pattern_gen
  import mem_test_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int WALK_W = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_restart,
  input  logic                i_step,
  input  mem_test_mode_t      i_mode,
  input  logic [31:0]         i_seed,
  input  logic [WALK_W-1:0]   i_index,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   o_pattern
);

  logic [31:0] r_lfsr;

  // LFSR reloads from the seed (zero forced to one) and advances once per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 32'd1;
    end else if (i_restart) begin
      r_lfsr <= (i_seed == 32'd0) ? 32'd1 : i_seed;
    end else if (i_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Select the pattern for the current word, truncated to the data width
  always_comb begin
    o_pattern = '0;
    case (i_mode)
      MODE_FIXED: o_pattern = i_seed[DATA_W-1:0];
      MODE_ADDR:  o_pattern = DATA_W'(i_addr);
      MODE_WALK1: o_pattern = DATA_W'(1) << i_index;
      default:    o_pattern = r_lfsr[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/mem_test_engine.sv
// Memory BIST: fills a word range with a pattern, reads it back and records miscompares.
// Latency: first request the cycle after start; one word per cycle with a zero-wait memory.
// Backpressure: each request is held unchanged until mem_ready; abort waits for the in-flight word.
module mem_test_engine
  import mem_test_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [1:0]        cfg_mode,
  input  logic [31:0]       cfg_seed,
  input  logic              cfg_stop_on_err,
  output logic              mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_store,
  output logic              mem_done,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_load,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam int                WALK_W     = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

  mem_test_state_t   r_state, w_state_nxt;
  mem_test_mode_t    r_mode;
  logic [ADDR_W-1:0] r_base, r_addr, r_fail_addr;
  logic [CNT_W-1:0]  r_count, r_idx;
  logic [31:0]       r_seed;
  logic              r_stop, r_abort_pend, r_pass, r_aborted;
  logic [ERR_W-1:0]  r_err;
  logic [DATA_W-1:0] r_fail_exp, r_fail_got;

  logic              w_busy, w_start_ok, w_last, w_abort_any, w_mismatch;
  logic              w_restart, w_step, w_rewind, w_finish;
  logic [31:0]       w_gen_seed;
  logic [DATA_W-1:0] w_pattern;

  assign w_busy      = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign w_start_ok  = start && !w_busy;
  assign w_last      = (r_idx == r_count - 1'b1);
  assign w_abort_any = abort || r_abort_pend;
  assign w_mismatch  = (r_state == ST_READ) && mem_ready && (mem_load != w_pattern);
  // The generator reloads from the incoming config on start, from the latched seed before READ
  assign w_gen_seed  = w_busy ? r_seed : cfg_seed;

  mem_test_pattern_gen #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .WALK_W(WALK_W)
  ) u_pattern_gen (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .i_step    (w_step),
    .i_mode    (r_mode),
    .i_seed    (w_gen_seed),
    .i_index   (r_idx[WALK_W-1:0]),
    .i_addr    (r_addr),
    .o_pattern (w_pattern)
  );

  // State register; reset drops the requests immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus the index/generator strobes for each completed word
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_step      = 1'b0;
    w_rewind    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_restart   = 1'b1;
          w_state_nxt = (cfg_count == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          if (w_abort_any) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
          end else if (w_last) begin
            w_state_nxt = ST_READ;
            w_restart   = 1'b1;
            w_rewind    = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (mem_ready) begin
          if (w_abort_any || w_last || (w_mismatch && r_stop)) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Config latch, word walk and result bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= MODE_FIXED;
      r_base       <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_seed       <= '0;
      r_stop       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_pass       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= '0;
      r_fail_addr  <= '0;
      r_fail_exp   <= '0;
      r_fail_got   <= '0;
    end else if (w_start_ok) begin
      r_mode       <= mem_test_mode_t'(cfg_mode);
      r_base       <= cfg_base & ALIGN_MASK;
      r_addr       <= cfg_base & ALIGN_MASK;
      r_count      <= cfg_count;
      r_idx        <= '0;
      r_seed       <= cfg_seed;
      r_stop       <= cfg_stop_on_err;
      r_abort_pend <= 1'b0;
      r_pass       <= (cfg_count == '0);
      r_aborted    <= 1'b0;
      r_err        <= '0;
      r_fail_addr  <= '0;
      r_fail_exp   <= '0;
      r_fail_got   <= '0;
    end else if (w_busy) begin
      // An abort is remembered until the in-flight word completes
      r_abort_pend <= w_abort_any && !mem_ready;
      if (w_mismatch) begin
        if (r_err != '1) r_err <= r_err + 1'b1;
        if (r_err == '0) begin
          r_fail_addr <= r_addr;
          r_fail_exp  <= w_pattern;
          r_fail_got  <= mem_load;
        end
      end
      if (w_step) begin
        r_idx  <= r_idx + 1'b1;
        r_addr <= r_addr + STRIDE_A;
      end
      if (w_rewind) begin
        r_idx  <= '0;
        r_addr <= r_base;
      end
      if (w_finish) begin
        r_aborted <= w_abort_any;
        r_pass    <= !w_abort_any && !w_mismatch && (r_err == '0);
      end
    end
  end

  assign mem_read  = (r_state == ST_READ);
  assign mem_write = (r_state == ST_WRITE) ? 2'b11 : 2'b00;
  assign mem_addr  = w_busy ? r_addr : '0;
  assign mem_store = (r_state == ST_WRITE) ? w_pattern : '0;
  assign mem_done  = w_busy && mem_ready;
  assign busy      = w_busy;
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign aborted   = r_aborted;
  assign err_count = r_err;
  assign fail_addr = r_fail_addr;
  assign fail_exp  = r_fail_exp;
  assign fail_got  = r_fail_got;

endmodule
